// File: rtl/ama_riscv_pipe_ctrl_pkg.sv
// Shared types for the fetch/decode pipeline flow controller.
// Optional perf counters in the top are enabled by AMA_PIPE_CTRL_PERF_EN.
package ama_riscv_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RST        = 2'd0,
    STEADY     = 2'd1,
    STALL_FLOW = 2'd2,
    STALL_IMEM = 2'd3
  } stall_state_t;

  localparam stall_state_t PIPE_CTRL_RST_VAL = RST;

  localparam int RF_AW_DFLT = 5;
  typedef logic [RF_AW_DFLT-1:0] rf_addr_t;

endpackage

// File: rtl/ama_riscv_pipe_ctrl_hazard_det.sv
// Load-use hazard compare between the EXE load destination and DEC sources.
// Purely combinational; x0 never creates a dependency.
module ama_riscv_hazard_det #(
  parameter int RF_AW = 5
) (
  input  logic             dec_val,
  input  logic             exe_load_inst,
  input  logic             exe_rd_we,
  input  logic [RF_AW-1:0] dec_rs1_addr,
  input  logic [RF_AW-1:0] dec_rs2_addr,
  input  logic [RF_AW-1:0] exe_rd_addr,
  output logic             hzd
);

  assign hzd = dec_val & exe_load_inst & exe_rd_we & (exe_rd_addr != '0) &
               ((exe_rd_addr == dec_rs1_addr) | (exe_rd_addr == dec_rs2_addr));

endmodule

// File: rtl/ama_riscv_pipe_ctrl.sv
// Front-end flow controller: sequences pc_we, IF/DEC stalls, EXE bubbles and DEC flushes.
// Perf counters (flow/imem/hazard) exist only when AMA_PIPE_CTRL_PERF_EN is defined.
module ama_riscv_pipe_ctrl
  import ama_riscv_pipe_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 2,
  parameter int RF_AW    = 5,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_rsp_val,
  input  logic             dec_val,
  input  logic             dec_branch_inst,
  input  logic             dec_jump_inst,
  input  logic [RF_AW-1:0] dec_rs1_addr,
  input  logic [RF_AW-1:0] dec_rs2_addr,
  input  logic             exe_load_inst,
  input  logic [RF_AW-1:0] exe_rd_addr,
  input  logic             exe_rd_we,
  input  logic             exe_flow_res,
  output logic             pc_we,
  output logic             stall_if,
  output logic             stall_dec,
  output logic             bubble_exe,
  output logic             flush_dec,
  output logic [1:0]       state_o
`ifdef AMA_PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_flow_cnt,
  output logic [CNT_W-1:0] perf_imem_cnt,
  output logic [CNT_W-1:0] perf_hzd_cnt
`endif
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  stall_state_t    state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            hzd;

  ama_riscv_hazard_det #(.RF_AW(RF_AW)) u_hazard_det (
    .dec_val       (dec_val),
    .exe_load_inst (exe_load_inst),
    .exe_rd_we     (exe_rd_we),
    .dec_rs1_addr  (dec_rs1_addr),
    .dec_rs2_addr  (dec_rs2_addr),
    .exe_rd_addr   (exe_rd_addr),
    .hzd           (hzd)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pc_we      = 1'b0;
    stall_if   = 1'b0;
    stall_dec  = 1'b0;
    bubble_exe = 1'b0;
    flush_dec  = 1'b0;
    case (state_q)
      RST: begin
        stall_if   = 1'b1;
        stall_dec  = 1'b1;
        bubble_exe = 1'b1;
        flush_dec  = 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = STEADY;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      STEADY: begin
        // Hazard wins over a branch in DEC: DEC is held, branch seen next cycle
        if (hzd) begin
          stall_if   = 1'b1;
          stall_dec  = 1'b1;
          bubble_exe = 1'b1;
        end else if (dec_val & (dec_branch_inst | dec_jump_inst)) begin
          state_d = STALL_FLOW;
        end else if (!imem_rsp_val) begin
          stall_if   = 1'b1;
          bubble_exe = 1'b1;
          state_d    = STALL_IMEM;
        end else begin
          pc_we = 1'b1;
        end
      end
      STALL_FLOW: begin
        flush_dec = 1'b1;
        if (exe_flow_res) begin
          pc_we   = 1'b1;
          state_d = STEADY;
        end else begin
          bubble_exe = 1'b1;
        end
      end
      STALL_IMEM: begin
        if (imem_rsp_val) begin
          pc_we   = 1'b1;
          state_d = STEADY;
        end else begin
          stall_if   = 1'b1;
          bubble_exe = 1'b1;
        end
      end
      default: state_d = PIPE_CTRL_RST_VAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PIPE_CTRL_RST_VAL;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign state_o = state_q;

`ifdef AMA_PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] flow_cnt_q, flow_cnt_d;
  logic [CNT_W-1:0] imem_cnt_q, imem_cnt_d;
  logic [CNT_W-1:0] hzd_cnt_q,  hzd_cnt_d;

  // Saturating counters: hold at all-ones rather than wrap
  always_comb begin
    flow_cnt_d = flow_cnt_q;
    imem_cnt_d = imem_cnt_q;
    hzd_cnt_d  = hzd_cnt_q;
    if ((state_q == STALL_FLOW) && (flow_cnt_q != '1)) flow_cnt_d = flow_cnt_q + CNT_W'(1);
    if ((state_q == STALL_IMEM) && (imem_cnt_q != '1)) imem_cnt_d = imem_cnt_q + CNT_W'(1);
    if ((state_q == STEADY) && hzd && (hzd_cnt_q != '1)) hzd_cnt_d = hzd_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flow_cnt_q <= '0;
      imem_cnt_q <= '0;
      hzd_cnt_q  <= '0;
    end else begin
      flow_cnt_q <= flow_cnt_d;
      imem_cnt_q <= imem_cnt_d;
      hzd_cnt_q  <= hzd_cnt_d;
    end
  end

  assign perf_flow_cnt = flow_cnt_q;
  assign perf_imem_cnt = imem_cnt_q;
  assign perf_hzd_cnt  = hzd_cnt_q;
`else
  logic cnt_w_unused;
  assign cnt_w_unused = ^CNT_W;
`endif

endmodule

// File: tb/tb_ama_riscv_pipe_ctrl.sv
// Scoreboard bench for ama_riscv_pipe_ctrl: directed scenarios then random traffic.
// Perf counter checks are active when AMA_PIPE_CTRL_PERF_EN is defined.
module tb_ama_riscv_pipe_ctrl;
  import ama_riscv_pipe_ctrl_pkg::*;

  localparam int RST_HOLD = 2;
  localparam int RF_AW    = 5;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, imem_rsp_val, dec_val, dec_branch_inst, dec_jump_inst;
  logic [RF_AW-1:0] dec_rs1_addr, dec_rs2_addr, exe_rd_addr;
  logic             exe_load_inst, exe_rd_we, exe_flow_res;
  logic             pc_we, stall_if, stall_dec, bubble_exe, flush_dec;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] perf_flow_cnt, perf_imem_cnt, perf_hzd_cnt;

  ama_riscv_pipe_ctrl #(.RST_HOLD(RST_HOLD), .RF_AW(RF_AW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_rsp_val    (imem_rsp_val),
    .dec_val         (dec_val),
    .dec_branch_inst (dec_branch_inst),
    .dec_jump_inst   (dec_jump_inst),
    .dec_rs1_addr    (dec_rs1_addr),
    .dec_rs2_addr    (dec_rs2_addr),
    .exe_load_inst   (exe_load_inst),
    .exe_rd_addr     (exe_rd_addr),
    .exe_rd_we       (exe_rd_we),
    .exe_flow_res    (exe_flow_res),
    .pc_we           (pc_we),
    .stall_if        (stall_if),
    .stall_dec       (stall_dec),
    .bubble_exe      (bubble_exe),
    .flush_dec       (flush_dec),
    .state_o         (state_o)
`ifdef AMA_PIPE_CTRL_PERF_EN
    ,
    .perf_flow_cnt   (perf_flow_cnt),
    .perf_imem_cnt   (perf_imem_cnt),
    .perf_hzd_cnt    (perf_hzd_cnt)
`endif
  );

`ifndef AMA_PIPE_CTRL_PERF_EN
  assign perf_flow_cnt = '0;
  assign perf_imem_cnt = '0;
  assign perf_hzd_cnt  = '0;
`endif

  typedef struct {
    logic [6:0]       ctrl;  // {pc_we, stall_if, stall_dec, bubble_exe, flush_dec, state}
    logic [CNT_W-1:0] flow;
    logic [CNT_W-1:0] imem;
    logic [CNT_W-1:0] hzd;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_n    = 0;

  // Reference model: cycles of reset hold left, plus "waiting" flags
  int               m_rst_left;
  bit               m_wait_flow, m_wait_imem;
  logic [CNT_W-1:0] m_pf, m_pi, m_ph;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_rst_left  = RST_HOLD;
    m_wait_flow = 0;
    m_wait_imem = 0;
    m_pf = '0; m_pi = '0; m_ph = '0;
  endtask

  task automatic step(input logic r, iv, dv, br, jp, input logic [4:0] rs1, rs2,
                      input logic ld, input logic [4:0] rd, input logic we, res);
    exp_t         e;
    bit           h, pw, si, sd, bx, fd;
    stall_state_t st;
    @(posedge clk); #1;
    rst = r; imem_rsp_val = iv; dec_val = dv; dec_branch_inst = br; dec_jump_inst = jp;
    dec_rs1_addr = rs1; dec_rs2_addr = rs2; exe_load_inst = ld; exe_rd_addr = rd;
    exe_rd_we = we; exe_flow_res = res;
    cyc_n++;

    h = dv && ld && we && (rd != 0) && (rd == rs1 || rd == rs2);
    {pw, si, sd, bx, fd} = 5'b0;
    if (m_rst_left > 0) begin
      st = RST; {si, sd, bx, fd} = 4'b1111;
    end else if (m_wait_flow) begin
      st = STALL_FLOW; fd = 1; pw = res; bx = !res;
    end else if (m_wait_imem) begin
      st = STALL_IMEM;
      if (iv) pw = 1; else begin si = 1; bx = 1; end
    end else begin
      st = STEADY;
      if (h) begin si = 1; sd = 1; bx = 1; end
      else if (dv && (br || jp)) pw = 0;
      else if (!iv) begin si = 1; bx = 1; end
      else pw = 1;
    end
    e.ctrl = {pw, si, sd, bx, fd, 2'(st)};
    e.flow = m_pf; e.imem = m_pi; e.hzd = m_ph; e.cyc = cyc_n;
    exp_q.push_back(e);

    if (!r) model_reset();
    else if (m_rst_left > 0) m_rst_left--;
    else if (m_wait_flow) begin
      m_pf = sat_inc(m_pf);
      if (res) m_wait_flow = 0;
    end else if (m_wait_imem) begin
      m_pi = sat_inc(m_pi);
      if (iv) m_wait_imem = 0;
    end else begin
      if (h) m_ph = sat_inc(m_ph);
      else if (dv && (br || jp)) m_wait_flow = 1;
      else if (!iv) m_wait_imem = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int c, input logic [CNT_W-1:0] got, exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl", e.cyc, CNT_W'({pc_we, stall_if, stall_dec, bubble_exe, flush_dec, state_o}),
            CNT_W'(e.ctrl));
`ifdef AMA_PIPE_CTRL_PERF_EN
        chk("perf_flow", e.cyc, perf_flow_cnt, e.flow);
        chk("perf_imem", e.cyc, perf_imem_cnt, e.imem);
        chk("perf_hzd",  e.cyc, perf_hzd_cnt,  e.hzd);
`endif
      end
    end
  end

  initial begin
    rst = 0; imem_rsp_val = 1; dec_val = 0; dec_branch_inst = 0; dec_jump_inst = 0;
    dec_rs1_addr = 0; dec_rs2_addr = 0; exe_load_inst = 0; exe_rd_addr = 0;
    exe_rd_we = 0; exe_flow_res = 0;
    @(posedge clk);
    model_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // lw x5 in EXE, add x6,x5,x1 in DEC
    step(1, 1, 1, 0, 0, 5, 1, 1, 5, 1, 0);
    idle(2);
    // beq in DEC, resolved two cycles later
    step(1, 1, 1, 1, 0, 1, 2, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // IMEM miss for three cycles
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // lw x0 never stalls; then hazard together with jal
    step(1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 5, 0, 1, 5, 1, 0);
    step(1, 1, 1, 0, 1, 5, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // Reset in the middle of an IMEM stall, then again during a flow stall
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    step(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // Random traffic with small register ranges to hit hazards often
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 9) < 4,
           5'($urandom_range(0, 3)), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
